// File: rtl/alu_arbiter.sv
// Purpose: two-requester front end to one shared combinational ALU. Tie-break is fixed priority by
//          default; define ALU_ARB_RR_EN for round-robin.
// Latency: 2 cycles from accept to respN_valid, one operation at a time, at least 3 cycles per operation.
// Backpressure: a result waits in RESP until its owner's resp ready; both request readys stay low meanwhile.
module alu_arbiter #(
  parameter int NREQ = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_op,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [31:0] resp_out,
  output logic        resp_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_op,
  input  logic [31:0] alu_out,
  input  logic        alu_zero
);

  // The two-port wiring below only makes sense for exactly two requesters.
  if (NREQ != 2) begin : g_nreq_check
    $error("alu_arbiter supports NREQ == 2 only");
  end

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] a_q, b_q;
  logic [3:0]  op_q;
  logic        owner_q;
  logic [31:0] res_q;
  logic        zero_q;
  logic        grant0, grant1;
  logic        acc, acc_id;

`ifdef ALU_ARB_RR_EN
  // Requester that wins the next tie; starts at 0 so requester 0 wins first.
  logic prio_q;

  // Round-robin grant: on a tie the requester named by prio_q wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    grant1 = req1_valid & (~req0_valid | prio_q);
    grant0 = req0_valid & ~grant1;
  end

  // After every accept the other requester gets priority.
  always_ff @(posedge clk) begin
    if (rst)      prio_q <= 1'b0;
    else if (acc) prio_q <= ~acc_id;
  end
`else
  // Fixed-priority grant: requester 0 always wins a tie.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    grant0 = req0_valid;
    grant1 = req1_valid & ~req0_valid;
  end
`endif

  assign req0_ready = (state == IDLE) & ~rst & grant0;
  assign req1_ready = (state == IDLE) & ~rst & grant1;
  assign acc        = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign acc_id     = req1_ready;

  assign resp0_valid = (state == RESP) & ~owner_q;
  assign resp1_valid = (state == RESP) &  owner_q;
  assign resp_out    = res_q;
  assign resp_zero   = zero_q;

  // The ALU sees the latched operands at all times, so its inputs move only on accept.
  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = op_q;

  // Next-state: accept starts EXEC, EXEC always lasts one cycle, RESP waits for the owner.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (acc) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (owner_q ? resp1_ready : resp0_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Operand latch on accept and result capture at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      owner_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      if (acc) begin
        a_q     <= acc_id ? req1_a  : req0_a;
        b_q     <= acc_id ? req1_b  : req0_b;
        op_q    <= acc_id ? req1_op : req0_op;
        owner_q <= acc_id;
      end
      if (state == EXEC) begin
        res_q  <= alu_out;
        zero_q <= alu_zero;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios followed by random traffic.
// A transaction-level model (busy flag, age since accept, last winner) predicts every output each cycle.
// The bench also plays the role of the shared ALU.
module tb_alu_arbiter;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic        resp0_valid, resp1_valid;
  logic        resp0_ready = 1'b0, resp1_ready = 1'b0;
  logic [31:0] resp_out;
  logic        resp_zero;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [3:0]  alu_op;
  logic        alu_zero;

  int n_checks = 0;
  int n_err    = 0;

  alu_arbiter #(.NREQ(2)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp_out(resp_out), .resp_zero(resp_zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return a << b[4:0];
      4'd6:    return a >> b[4:0];
      4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return ~a;
    endcase
  endfunction

  assign alu_out  = alu_f(alu_a, alu_b, alu_op);
  assign alu_zero = (alu_out == 32'd0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model state
  bit          m_init = 0;
  bit          m_busy = 0;
  int          m_age  = 0;
  bit          m_owner = 0;
  bit          m_last  = 1;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic [3:0]  m_op = '0;
  logic        m_zero = 1'b0;

  // Accept bookkeeping for the driver and directed checks
  bit lacc0 = 0, lacc1 = 0;
  int acc_log[$];

  // Compare DUT to model each cycle, then advance the model across the coming edge.
  always @(negedge clk) begin
    bit has, win;
    bit e_r0, e_r1;
    has = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      win = ~m_last;
`else
      win = 1'b0;
`endif
    end else begin
      win = req1_valid;
    end
    e_r0 = !rst && !m_busy && has && (win == 1'b0);
    e_r1 = !rst && !m_busy && has && (win == 1'b1);

    if (m_init) begin
      chk("req0_ready", {31'd0, req0_ready}, {31'd0, e_r0});
      chk("req1_ready", {31'd0, req1_ready}, {31'd0, e_r1});
      chk("resp0_valid", {31'd0, resp0_valid}, {31'd0, m_busy && m_age == 2 && !m_owner});
      chk("resp1_valid", {31'd0, resp1_valid}, {31'd0, m_busy && m_age == 2 && m_owner});
      chk("resp_out", resp_out, m_res);
      chk("resp_zero", {31'd0, resp_zero}, {31'd0, m_zero});
      chk("alu_a", alu_a, m_a);
      chk("alu_b", alu_b, m_b);
      chk("alu_op", {28'd0, alu_op}, {28'd0, m_op});
    end

    lacc0 = !rst && req0_valid && req0_ready;
    lacc1 = !rst && req1_valid && req1_ready;
    if (lacc0) acc_log.push_back(0);
    if (lacc1) acc_log.push_back(1);

    if (rst) begin
      m_init = 1; m_busy = 0; m_age = 0; m_owner = 0; m_last = 1;
      m_a = '0; m_b = '0; m_op = '0; m_res = '0; m_zero = 1'b0;
    end else if (!m_busy) begin
      if (has) begin
        m_busy = 1; m_age = 1; m_owner = win; m_last = win;
        m_a  = win ? req1_a  : req0_a;
        m_b  = win ? req1_b  : req0_b;
        m_op = win ? req1_op : req0_op;
      end
    end else if (m_age == 1) begin
      m_res  = alu_f(m_a, m_b, m_op);
      m_zero = (m_res == 32'd0);
      m_age  = 2;
    end else if (m_owner ? resp1_ready : resp0_ready) begin
      m_busy = 0;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic neg;
    @(negedge clk);
    #1;
  endtask

  int exp_g[4];

  initial begin
`ifdef ALU_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    // Reset
    repeat (2) tick;
    rst = 0;
    neg;
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_resp_out", resp_out, 32'd0);
    chk("rst_resp0_valid", {31'd0, resp0_valid}, 32'd0);

    // Single op 5 + 3
    tick;
    req0_valid = 1; req0_a = 32'd5; req0_b = 32'd3; req0_op = ALU_ADD;
    neg;
    chk("t1_req0_ready", {31'd0, req0_ready}, 32'd1);
    tick; req0_valid = 0;
    tick;
    neg;
    chk("t1_resp0_valid", {31'd0, resp0_valid}, 32'd1);
    chk("t1_resp_out", resp_out, 32'd8);
    chk("t1_resp_zero", {31'd0, resp_zero}, 32'd0);
    tick; resp0_ready = 1;
    tick; resp0_ready = 0;

    // Zero flag via requester 1
    req1_valid = 1; req1_a = 32'h1234; req1_b = 32'h1234; req1_op = ALU_SUB;
    tick; req1_valid = 0;
    tick;
    neg;
    chk("t2_resp1_valid", {31'd0, resp1_valid}, 32'd1);
    chk("t2_resp0_valid", {31'd0, resp0_valid}, 32'd0);
    chk("t2_resp_out", resp_out, 32'd0);
    chk("t2_resp_zero", {31'd0, resp_zero}, 32'd1);
    tick; resp1_ready = 1;
    tick; resp1_ready = 0;

    // Contention: four back-to-back operations
    acc_log.delete();
    req0_valid = 1; req0_a = 32'd10; req0_b = 32'd20; req0_op = ALU_ADD;
    req1_valid = 1; req1_a = 32'd7;  req1_b = 32'd2;  req1_op = ALU_SUB;
    resp0_ready = 1; resp1_ready = 1;
    repeat (12) tick;
    req0_valid = 0; req1_valid = 0;
    chk("t3_grant_count", acc_log.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < acc_log.size()) chk($sformatf("t3_grant%0d", i), acc_log[i], exp_g[i]);
    tick; resp0_ready = 0; resp1_ready = 0;

    // Backpressure: result held 10 cycles while req1 waits
    req0_valid = 1; req0_a = 32'hF0; req0_b = 32'h0F; req0_op = 4'd3;
    tick; req0_valid = 0;
    tick;
    req1_valid = 1; req1_a = 32'd100; req1_b = 32'd1; req1_op = ALU_ADD;
    for (int i = 0; i < 10; i++) begin
      neg;
      chk("t4_req1_ready_held", {31'd0, req1_ready}, 32'd0);
      chk("t4_resp_out_held", resp_out, 32'hFF);
      tick;
    end
    resp0_ready = 1;
    tick; resp0_ready = 0;
    neg;
    chk("t4_req1_accept", {31'd0, req1_ready}, 32'd1);
    tick; req1_valid = 0;
    tick; tick; resp1_ready = 1;
    tick; resp1_ready = 0;

    // Reset during EXEC
    req0_valid = 1; req0_a = 32'd9; req0_b = 32'd4; req0_op = ALU_ADD;
    tick; req0_valid = 0; rst = 1;
    tick; rst = 0;
    req0_valid = 1; req0_a = 32'd1; req0_b = 32'd1; req0_op = ALU_ADD;
    neg;
    chk("t5_resp_out", resp_out, 32'd0);
    chk("t5_resp0_valid", {31'd0, resp0_valid}, 32'd0);
    chk("t5_req0_ready", {31'd0, req0_ready}, 32'd1);
    tick; req0_valid = 0;
    tick; tick; resp0_ready = 1;
    tick; resp0_ready = 0;

    // Withdrawn request during RESP
    acc_log.delete();
    req0_valid = 1; req0_a = 32'd3; req0_b = 32'd3; req0_op = 4'd4;
    tick; req0_valid = 0;
    tick;
    req1_valid = 1; req1_a = 32'd5; req1_b = 32'd6; req1_op = ALU_ADD;
    tick; req1_valid = 0;
    tick; resp0_ready = 1;
    tick; resp0_ready = 0;
    repeat (3) tick;
    chk("t6_accept_count", acc_log.size(), 32'd1);
    if (acc_log.size() > 0) chk("t6_accept_id", acc_log[0], 32'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      tick;
      rst = ($urandom_range(63) == 0);
      if (lacc0 || (req0_valid && $urandom_range(7) == 0)) req0_valid = 0;
      else if (!req0_valid && $urandom_range(1) == 1) begin
        req0_valid = 1; req0_a = $urandom;
        req0_b = ($urandom_range(3) == 0) ? req0_a : $urandom;
        req0_op = 4'($urandom_range(8));
      end
      if (lacc1 || (req1_valid && $urandom_range(7) == 0)) req1_valid = 0;
      else if (!req1_valid && $urandom_range(1) == 1) begin
        req1_valid = 1; req1_a = $urandom;
        req1_b = ($urandom_range(3) == 0) ? req1_a : $urandom;
        req1_op = 4'($urandom_range(8));
      end
      resp0_ready = ($urandom_range(3) != 0);
      resp1_ready = ($urandom_range(3) != 0);
    end
    tick;
    rst = 0; req0_valid = 0; req1_valid = 0; resp0_ready = 1; resp1_ready = 1;
    repeat (5) tick;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
